// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, state
// register encoding, and the ALU operand/op select codes.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/mc_ctrl_perf.sv
// Retired-instruction and memory-stall counters for the control FSM.
// Only built when MC_CTRL_PERF_EN is defined; both wrap at 2^32.
module mc_ctrl_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        retire,
  input  logic        stall,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + 32'd1;
      if (stall)  stall_cnt   <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I main control FSM (R-type, addi, lw, sw, beq).
// Define MC_CTRL_PERF_EN to build the retired/stall counters.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        pc_en,
  output logic        PCSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        Branch,
  output logic        Regwrite,
  output logic        MemtoReg,
  output logic        illegal_op,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  state_t state, state_nxt;
  logic   pcwrite;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    pcwrite    = 1'b0;
    PCSrc      = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALUOP_ADD;
    Branch     = 1'b0;
    Regwrite   = 1'b0;
    MemtoReg   = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // IR and PC+4 commit only on the cycle the memory delivers
        if (mem_ready) begin
          IRWrite   = 1'b1;
          pcwrite   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM;
        case (Opcode)
          OP_RTYPE:           state_nxt = S_EXEC_R;
          OP_ITYPE:           state_nxt = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
          OP_BRANCH:          state_nxt = S_BRANCH;
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        Regwrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (Opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        Regwrite  = 1'b1;
        MemtoReg  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALUOP_SUB;
        Branch    = 1'b1;
        PCSrc     = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pc_en = pcwrite | (Branch & Zero);

`ifdef MC_CTRL_PERF_EN
  logic retire, stall;

  // illegal-opcode returns leave DECODE, so they never count as retired
  assign retire = (state == S_ALU_WB) || (state == S_MEM_WB) || (state == S_BRANCH) ||
                  ((state == S_MEM_WRITE) && mem_ready);
  assign stall  = !mem_ready &&
                  ((state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE));

  mc_ctrl_perf u_perf (
    .clk         (clk),
    .reset       (reset),
    .retire      (retire),
    .stall       (stall),
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
  );
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule
